wb_arbiter: RTL and testbench

Single-write-port writeback arbiter for the physical register file. Accepts write requests from up to NUM_REQ execution units via a valid/ready handshake and grants one per cycle in round-robin order. Registers the winning tag and data, then drives a one-hot per-entry write-enable vector straight onto the `we` pins of the register file's enable-gated flop bank.

---
 rtl/wb_pkg.sv | 8 +
 rtl/wb_arbiter_dff_we.sv | 17 +
 rtl/wb_arbiter_rr_picker.sv | 50 +++++
 rtl/wb_arbiter.sv | 75 +++++++
 tb/tb_wb_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared sizing constants for the physical register file writeback arbiter.
package wb_pkg;
   localparam int NUM_REQ      = 4;
   localparam int TAG_WIDTH    = 6;
   localparam int DATA_WIDTH   = 32;
   localparam int RR_PTR_WIDTH = $clog2(NUM_REQ);
   localparam int PRF_DEPTH    = 2**TAG_WIDTH;
endpackage

// File: rtl/wb_arbiter_dff_we.sv
// Write-enabled register cell with asynchronous active-high clear.
module dff_we #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     q <= '0;
      else if (we) q <= d;
   end

endmodule

// File: rtl/wb_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate the valid vector so rr_ptr sits at
// bit 0, take the lowest set bit, then rotate the result back.
module rr_picker
   import wb_pkg::*;
#(
   parameter int NUM_REQ = wb_pkg::NUM_REQ,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   winner
);

   logic [NUM_REQ-1:0] rotated;
   logic [PTR_W-1:0]   sel;
   logic               found;
   int                 idx;
   int                 offset;

   always_comb begin
      rotated = '0;
      grant   = '0;
      winner  = '0;
      sel     = '0;
      found   = 1'b0;
      offset  = 0;
      idx     = 0;
      for (int j = 0; j < NUM_REQ; j++) begin
         idx = j + int'(ptr);
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         sel = PTR_W'(idx);
         rotated[j] = valid[sel];
      end
      // Scan downward so the lowest set bit of the rotated vector wins.
      for (int j = NUM_REQ-1; j >= 0; j--) begin
         if (rotated[j]) begin
            found  = 1'b1;
            offset = j;
         end
      end
      idx = offset + int'(ptr);
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (found) begin
         winner     = PTR_W'(idx);
         grant[winner] = 1'b1;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: one granted write per cycle into a registered
// write port, with a one-hot per-entry write-enable decode for the flop bank.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int NUM_REQ    = wb_pkg::NUM_REQ,
   parameter int TAG_WIDTH  = wb_pkg::TAG_WIDTH,
   parameter int DATA_WIDTH = wb_pkg::DATA_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst_aH,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          stall,
   input  logic                          flush,
   output logic                          wr_en,
   output logic [TAG_WIDTH-1:0]          wr_tag,
   output logic [DATA_WIDTH-1:0]         wr_data,
   output logic [2**TAG_WIDTH-1:0]       wr_we_vec
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]   rr_ptr;
   logic [NUM_REQ-1:0] grant;
   logic [PTR_W-1:0]   winner;
   logic               transfer;

   rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
      .valid  (req_valid),
      .ptr    (rr_ptr),
      .grant  (grant),
      .winner (winner)
   );

   // Reset is folded into the gate so a grant seen while reset is high never
   // reaches a requester.
   assign req_ready = (stall || flush || rst_aH) ? '0 : grant;
   assign transfer  = |req_ready;

   always_ff @(posedge clk or posedge rst_aH) begin
      if (rst_aH) begin
         rr_ptr <= '0;
         wr_en  <= 1'b0;
      end else begin
         wr_en <= transfer;
         if (transfer)
            rr_ptr <= (winner == PTR_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
      end
   end

   dff_we #(.WIDTH(TAG_WIDTH)) u_tag_reg (
      .clk (clk),
      .rst (rst_aH),
      .we  (transfer),
      .d   (req_tag[winner*TAG_WIDTH +: TAG_WIDTH]),
      .q   (wr_tag)
   );

   dff_we #(.WIDTH(DATA_WIDTH)) u_data_reg (
      .clk (clk),
      .rst (rst_aH),
      .we  (transfer),
      .d   (req_data[winner*DATA_WIDTH +: DATA_WIDTH]),
      .q   (wr_data)
   );

   always_comb begin
      wr_we_vec = '0;
      wr_we_vec[wr_tag] = wr_en;
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_wb_arbiter;

   localparam int N  = 4;
   localparam int TW = 6;
   localparam int DW = 32;

   logic              clk = 1'b0;
   logic              rst_aH;
   logic [N-1:0]      req_valid;
   logic [N*TW-1:0]   req_tag;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      req_ready;
   logic              stall;
   logic              flush;
   logic              wr_en;
   logic [TW-1:0]     wr_tag;
   logic [DW-1:0]     wr_data;
   logic [2**TW-1:0]  wr_we_vec;

   int total  = 0;
   int passed = 0;

   wb_arbiter #(.NUM_REQ(N), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst_aH    (rst_aH),
      .req_valid (req_valid),
      .req_tag   (req_tag),
      .req_data  (req_data),
      .req_ready (req_ready),
      .stall     (stall),
      .flush     (flush),
      .wr_en     (wr_en),
      .wr_tag    (wr_tag),
      .wr_data   (wr_data),
      .wr_we_vec (wr_we_vec)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]  valid;
      logic          stall;
      logic          flush;
      logic [N-1:0]  ready;
      logic          en;
      logic [TW-1:0] tag;
   } vec_t;

   vec_t vecs[21];

   // Behavioural model state for the randomized phase.
   int            m_ptr;
   logic          m_en;
   logic [TW-1:0] m_tag;
   logic [DW-1:0] m_data;
   logic          pend[N];
   logic [TW-1:0] ptag[N];
   logic [DW-1:0] pdata[N];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp)
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      else
         passed++;
   endtask

   task automatic checkOutput(input string name, input logic [N-1:0] er, input logic ee,
                              input logic [TW-1:0] et, input logic [DW-1:0] ed);
      check({name, ".ready"}, 64'(req_ready), 64'(er));
      check({name, ".wr_en"}, 64'(wr_en), 64'(ee));
      if (ee) begin
         check({name, ".wr_tag"}, 64'(wr_tag), 64'(et));
         check({name, ".wr_data"}, 64'(wr_data), 64'(ed));
      end
      check({name, ".we_vec"}, 64'(wr_we_vec), ee ? (64'd1 << et) : 64'd0);
   endtask

   task automatic setUnit(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
      req_tag[i*TW +: TW]  = t;
      req_data[i*DW +: DW] = d;
   endtask

   task automatic applyStimulus(input logic [N-1:0] v, input logic s, input logic f);
      req_valid = v;
      stall     = s;
      flush     = f;
   endtask

   task automatic setDefaultTags();
      for (int i = 0; i < N; i++) setUnit(i, TW'(4 + i), 32'h1000_0000 + 32'(i));
   endtask

   task automatic doReset();
      applyStimulus('0, 1'b0, 1'b0);
      rst_aH = 1'b1;
      @(posedge clk);
      #1 rst_aH = 1'b0;
   endtask

   // Winner chosen straight from the rule: first valid unit at or after ptr.
   function automatic int modelGrant(input logic [N-1:0] v, input logic s, input logic f, input int ptr);
      if (s || f) return -1;
      for (int k = 0; k < N; k++)
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   initial begin
      logic [N-1:0]  v;
      logic          s, f;
      int            w;

      req_tag  = '0;
      req_data = '0;
      setDefaultTags();

      // Reset asserted with requests present: everything must read zero.
      rst_aH = 1'b1;
      applyStimulus('1, 1'b0, 1'b0);
      #2;
      checkOutput("reset", '0, 1'b0, '0, '0);
      check("reset.wr_tag", 64'(wr_tag), 64'd0);
      check("reset.wr_data", 64'(wr_data), 64'd0);
      @(posedge clk);
      #1 rst_aH = 1'b0;

      //           valid    st    fl    ready    en    tag
      vecs[0]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0, 6'd0};
      vecs[1]  = '{4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 6'd4};
      vecs[2]  = '{4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 6'd5};
      vecs[3]  = '{4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 6'd6};
      vecs[4]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 6'd7};
      vecs[5]  = '{4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 6'd4};
      vecs[6]  = '{4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 6'd5};
      vecs[7]  = '{4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 6'd6};
      vecs[8]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 6'd7};
      vecs[9]  = '{4'b0101, 1'b1, 1'b0, 4'b0000, 1'b0, 6'd0};
      vecs[10] = '{4'b0101, 1'b1, 1'b0, 4'b0000, 1'b0, 6'd0};
      vecs[11] = '{4'b0101, 1'b0, 1'b0, 4'b0001, 1'b0, 6'd0};
      vecs[12] = '{4'b0101, 1'b0, 1'b0, 4'b0100, 1'b1, 6'd4};
      vecs[13] = '{4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 6'd6};
      vecs[14] = '{4'b1010, 1'b0, 1'b0, 4'b1000, 1'b1, 6'd5};
      vecs[15] = '{4'b1010, 1'b0, 1'b0, 4'b0010, 1'b1, 6'd7};
      vecs[16] = '{4'b0010, 1'b0, 1'b1, 4'b0000, 1'b1, 6'd5};
      vecs[17] = '{4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 6'd0};
      vecs[18] = '{4'b1111, 1'b0, 1'b0, 4'b0100, 1'b0, 6'd0};
      vecs[19] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 6'd6};
      vecs[20] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 6'd0};

      for (int k = 0; k < 21; k++) begin
         applyStimulus(vecs[k].valid, vecs[k].stall, vecs[k].flush);
         @(negedge clk);
         checkOutput($sformatf("vec%0d", k), vecs[k].ready, vecs[k].en, vecs[k].tag,
                     32'h1000_0000 + 32'(vecs[k].tag) - 32'd4);
         @(posedge clk);
         #1;
      end

      // Flush after grant: the captured write completes, no new grant.
      doReset();
      setUnit(1, 6'd9, 32'hDEAD_BEEF);
      applyStimulus(4'b0010, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("flush.t", 4'b0010, 1'b0, '0, '0);
      @(posedge clk);
      #1 applyStimulus(4'b0001, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("flush.t1", 4'b0000, 1'b1, 6'd9, 32'hDEAD_BEEF);
      @(posedge clk);
      #1 applyStimulus(4'b0000, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("flush.t2", 4'b0000, 1'b0, '0, '0);
      @(posedge clk);
      #1;

      // Single requester streaming tags 10..14 regardless of pointer.
      doReset();
      for (int k = 0; k < 6; k++) begin
         if (k < 5) begin
            setUnit(2, TW'(10 + k), 32'hC0DE_0000 + 32'(k));
            applyStimulus(4'b0100, 1'b0, 1'b0);
         end else begin
            applyStimulus(4'b0000, 1'b0, 1'b0);
         end
         @(negedge clk);
         checkOutput($sformatf("single%0d", k), (k < 5) ? 4'b0100 : 4'b0000, k > 0,
                     TW'(9 + k), 32'hC0DE_0000 + 32'(k - 1));
         @(posedge clk);
         #1;
      end

      // Asynchronous reset pulsed between edges while all units request.
      doReset();
      setDefaultTags();
      applyStimulus(4'b1111, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst_aH = 1'b1;
      #1;
      checkOutput("midrst", '0, 1'b0, '0, '0);
      check("midrst.wr_tag", 64'(wr_tag), 64'd0);
      check("midrst.wr_data", 64'(wr_data), 64'd0);
      #1 rst_aH = 1'b0;
      @(negedge clk);
      checkOutput("midrst.rel", 4'b0001, 1'b0, '0, '0);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("midrst.next", 4'b0010, 1'b1, 6'd4, 32'h1000_0000);
      @(posedge clk);
      #1;

      // Randomized traffic against the behavioural model.
      doReset();
      m_ptr  = 0;
      m_en   = 1'b0;
      m_tag  = '0;
      m_data = '0;
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) != 0) begin
               pend[i]  = 1'b1;
               ptag[i]  = TW'($urandom);
               pdata[i] = $urandom;
               setUnit(i, ptag[i], pdata[i]);
            end
            v[i] = pend[i];
         end
         s = ($urandom_range(0, 5) == 0);
         f = ($urandom_range(0, 7) == 0);
         applyStimulus(v, s, f);
         w = modelGrant(v, s, f, m_ptr);
         @(negedge clk);
         checkOutput($sformatf("rand%0d", cyc), (w < 0) ? '0 : N'(1 << w), m_en, m_tag, m_data);
         @(posedge clk);
         if (w >= 0) begin
            m_en    = 1'b1;
            m_tag   = ptag[w];
            m_data  = pdata[w];
            m_ptr   = (w + 1) % N;
            pend[w] = 1'b0;
         end else begin
            m_en = 1'b0;
         end
         #1;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
